// File: rtl/multicore_system_dpram_pkg.sv
// Shared types and helpers for the multicore system dual-port RAM.
//   state_t          : zero-fill FSM state (ST_CLEAR, ST_READY)
//   bytes_of()       : number of byte lanes in a data word
//   parity_of_lane() : even-parity bit of one byte lane
package multicore_system_dpram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

  // Stored bit makes the lane plus its parity bit contain an even number of ones.
  function automatic logic parity_of_lane(input logic [7:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/multicore_system_dpram_port.sv
// One Avalon-MM slave port of the dual-port RAM: accept logic, read-valid
// pipeline and optional output register.
//   clk, reset          : clock, async active-high reset
//   ready               : array initialised, port may accept
//   reset_req, clken    : global freeze / per-port stall
//   chipselect, read, write : Avalon request
//   rdata_raw, rerr_raw : array read data and parity error at current address
//   rd_acc, wr_acc      : accepted read / accepted write this cycle
//   readdata, readdatavalid, readerror, waitrequest : Avalon response
module multicore_system_dpram_port #(
  parameter int DATA_W  = 32,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              reset_req,
  input  logic              clken,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] rdata_raw,
  input  logic              rerr_raw,
  output logic              rd_acc,
  output logic              wr_acc,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              readerror,
  output logic              waitrequest
);

  logic              en;
  logic              acc;
  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              err_p0;

  assign en          = clken & ~reset_req;
  assign acc         = ready & chipselect & (read | write) & en;
  // A simultaneous read and write performs only the write.
  assign wr_acc      = acc & write;
  assign rd_acc      = acc & read & ~write;
  assign waitrequest = reset | ~ready | reset_req;

  // Stage p0: array read captured on accept; data holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      err_p0  <= 1'b0;
    end else if (en) begin
      vld_p0 <= rd_acc;
      if (rd_acc) begin
        data_p0 <= rdata_raw;
        err_p0  <= rerr_raw;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              vld_p1;
      logic [DATA_W-1:0] data_p1;
      logic              err_p1;

      // Stage p1: optional output register, stalls with the port.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
          err_p1  <= 1'b0;
        end else if (en) begin
          vld_p1 <= vld_p0;
          if (vld_p0) begin
            data_p1 <= data_p0;
            err_p1  <= err_p0;
          end
        end
      end

      assign readdata      = data_p1;
      assign readdatavalid = vld_p1;
      assign readerror     = vld_p1 & err_p1;
    end else begin : g_no_out_reg
      assign readdata      = data_p0;
      assign readdatavalid = vld_p0;
      assign readerror     = vld_p0 & err_p0;
    end
  endgenerate

endmodule

// File: rtl/multicore_system_dpram_ctrl.sv
// Parametrised true dual-port tightly-coupled memory with two Avalon-MM
// slaves (a = s1, b = s2), post-reset zero fill and a sticky collision flag.
//   clk, reset              : clock, async active-high reset
//   reset_req               : freezes both ports
//   clear_collision         : clears the collision flag
//   {a,b}_* Avalon slave    : address, byteenable, chipselect, read, write,
//                             writedata, clken, readdata, readdatavalid,
//                             waitrequest, readerror
//   init_busy               : zero fill in progress
//   collision               : sticky same-address dual-write flag
// Optional macro MCS_DPRAM_PARITY_EN adds per-lane even parity and readerror.
module multicore_system_dpram_ctrl
  import multicore_system_dpram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 4096,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reset_req,
  input  logic                   clear_collision,
  input  logic [ADDR_W-1:0]      a_address,
  input  logic [DATA_W/8-1:0]    a_byteenable,
  input  logic                   a_chipselect,
  input  logic                   a_read,
  input  logic                   a_write,
  input  logic [DATA_W-1:0]      a_writedata,
  input  logic                   a_clken,
  output logic [DATA_W-1:0]      a_readdata,
  output logic                   a_readdatavalid,
  output logic                   a_waitrequest,
  output logic                   a_readerror,
  input  logic [ADDR_W-1:0]      b_address,
  input  logic [DATA_W/8-1:0]    b_byteenable,
  input  logic                   b_chipselect,
  input  logic                   b_read,
  input  logic                   b_write,
  input  logic [DATA_W-1:0]      b_writedata,
  input  logic                   b_clken,
  output logic [DATA_W-1:0]      b_readdata,
  output logic                   b_readdatavalid,
  output logic                   b_waitrequest,
  output logic                   b_readerror,
  output logic                   init_busy,
  output logic                   collision
);

  localparam int                NB        = bytes_of(DATA_W);
  localparam logic [ADDR_W:0]   DEPTH_C   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clear_addr;
  logic              clr_we;
  logic              ready;
  logic              a_rd_acc, a_wr_acc, b_rd_acc, b_wr_acc;
  logic              a_in_range, b_in_range;
  logic              a_wr_ok, b_wr_ok, both_same;
  logic [DATA_W-1:0] a_raw, b_raw;
  logic              a_err_raw, b_err_raw;

  assign ready      = (state == ST_READY);
  assign init_busy  = (state == ST_CLEAR);
  assign a_in_range = {1'b0, a_address} < DEPTH_C;
  assign b_in_range = {1'b0, b_address} < DEPTH_C;
  assign a_raw      = a_in_range ? mem[a_address] : '0;
  assign b_raw      = b_in_range ? mem[b_address] : '0;

  // Port A wins a same-address dual write; port B's write is dropped whole.
  assign both_same  = a_wr_acc & b_wr_acc & (a_address == b_address);
  assign a_wr_ok    = a_wr_acc & a_in_range;
  assign b_wr_ok    = b_wr_acc & b_in_range & ~both_same;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clear_addr <= '0;
    end else begin
      state <= state_nx;
      if (clr_we) clear_addr <= clear_addr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    clr_we   = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clear_addr == LAST_ADDR) state_nx = ST_READY;
      end
      default: state_nx = ST_READY;
    endcase
  end

  // Array contents are deliberately not reset; the FSM zero-fills them.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clear_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (a_wr_ok && a_byteenable[i]) mem[a_address][i*8 +: 8] <= a_writedata[i*8 +: 8];
        if (b_wr_ok && b_byteenable[i]) mem[b_address][i*8 +: 8] <= b_writedata[i*8 +: 8];
      end
    end
  end

`ifdef MCS_DPRAM_PARITY_EN
  logic [NB-1:0] mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_par[clear_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (a_wr_ok && a_byteenable[i]) mem_par[a_address][i] <= parity_of_lane(a_writedata[i*8 +: 8]);
        if (b_wr_ok && b_byteenable[i]) mem_par[b_address][i] <= parity_of_lane(b_writedata[i*8 +: 8]);
      end
    end
  end

  always_comb begin
    a_err_raw = 1'b0;
    b_err_raw = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (a_in_range && (parity_of_lane(mem[a_address][i*8 +: 8]) != mem_par[a_address][i])) a_err_raw = 1'b1;
      if (b_in_range && (parity_of_lane(mem[b_address][i*8 +: 8]) != mem_par[b_address][i])) b_err_raw = 1'b1;
    end
  end
`else
  assign a_err_raw = 1'b0;
  assign b_err_raw = 1'b0;
`endif

  // Set has priority over clear when both happen in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) collision <= 1'b0;
    else if (both_same) collision <= 1'b1;
    else if (clear_collision) collision <= 1'b0;
  end

  multicore_system_dpram_port #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_port_a (
    .clk(clk), .reset(reset), .ready(ready), .reset_req(reset_req), .clken(a_clken),
    .chipselect(a_chipselect), .read(a_read), .write(a_write),
    .rdata_raw(a_raw), .rerr_raw(a_err_raw), .rd_acc(a_rd_acc), .wr_acc(a_wr_acc),
    .readdata(a_readdata), .readdatavalid(a_readdatavalid),
    .readerror(a_readerror), .waitrequest(a_waitrequest)
  );

  multicore_system_dpram_port #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_port_b (
    .clk(clk), .reset(reset), .ready(ready), .reset_req(reset_req), .clken(b_clken),
    .chipselect(b_chipselect), .read(b_read), .write(b_write),
    .rdata_raw(b_raw), .rerr_raw(b_err_raw), .rd_acc(b_rd_acc), .wr_acc(b_wr_acc),
    .readdata(b_readdata), .readdatavalid(b_readdatavalid),
    .readerror(b_readerror), .waitrequest(b_waitrequest)
  );

endmodule

// File: tb/tb_multicore_system_dpram_ctrl.sv
// Directed bench for multicore_system_dpram_ctrl. Two instances share all
// inputs: u_dut0 (DEPTH=16, OUT_REG=0) and u_dut1 (DEPTH=12, OUT_REG=1).
module tb_multicore_system_dpram_ctrl;

  logic        clk = 1'b0;
  logic        reset, reset_req, clear_collision;
  logic [3:0]  a_address, b_address, a_byteenable, b_byteenable;
  logic        a_chipselect, a_read, a_write, a_clken;
  logic        b_chipselect, b_read, b_write, b_clken;
  logic [31:0] a_writedata, b_writedata;

  logic [31:0] a_rd [2];
  logic [31:0] b_rd [2];
  logic        a_rv [2];
  logic        b_rv [2];
  logic        a_wq [2];
  logic        b_wq [2];
  logic        a_re [2];
  logic        b_re [2];
  logic        busy [2];
  logic        coll [2];

  int          checks = 0;
  int          errors = 0;
  int          lat [2][2];
  int          vc  [2][2];
  logic [31:0] dat [2][2];
  logic        err [2][2];
  logic        col_after [2];

  always #5 clk = ~clk;

  multicore_system_dpram_ctrl #(.DATA_W(32), .DEPTH(16), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clear_collision(clear_collision),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_chipselect(a_chipselect),
    .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata), .a_clken(a_clken),
    .a_readdata(a_rd[0]), .a_readdatavalid(a_rv[0]), .a_waitrequest(a_wq[0]), .a_readerror(a_re[0]),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_chipselect(b_chipselect),
    .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata), .b_clken(b_clken),
    .b_readdata(b_rd[0]), .b_readdatavalid(b_rv[0]), .b_waitrequest(b_wq[0]), .b_readerror(b_re[0]),
    .init_busy(busy[0]), .collision(coll[0])
  );

  multicore_system_dpram_ctrl #(.DATA_W(32), .DEPTH(12), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clear_collision(clear_collision),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_chipselect(a_chipselect),
    .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata), .a_clken(a_clken),
    .a_readdata(a_rd[1]), .a_readdatavalid(a_rv[1]), .a_waitrequest(a_wq[1]), .a_readerror(a_re[1]),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_chipselect(b_chipselect),
    .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata), .b_clken(b_clken),
    .b_readdata(b_rd[1]), .b_readdatavalid(b_rv[1]), .b_waitrequest(b_wq[1]), .b_readerror(b_re[1]),
    .init_busy(busy[1]), .collision(coll[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request cycle on each port (en=0 idles the port, wr=0 reads), then
  // five cycles of observation of both instances' responses.
  task automatic access(input logic ae, input logic aw, input logic [3:0] aad,
                        input logic [31:0] awd, input logic [3:0] abe,
                        input logic be, input logic bw, input logic [3:0] bad,
                        input logic [31:0] bwd, input logic [3:0] bbe);
    a_chipselect = ae; a_read = ae & ~aw; a_write = ae & aw;
    a_address = aad; a_writedata = awd; a_byteenable = abe;
    b_chipselect = be; b_read = be & ~bw; b_write = be & bw;
    b_address = bad; b_writedata = bwd; b_byteenable = bbe;
    step();
    for (int d = 0; d < 2; d++) begin
      col_after[d] = coll[d];
      for (int p = 0; p < 2; p++) begin
        lat[d][p] = 0; vc[d][p] = 0; dat[d][p] = 32'hx; err[d][p] = 1'bx;
      end
    end
    a_chipselect = 1'b0; a_read = 1'b0; a_write = 1'b0;
    b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (a_rv[d]) begin
          if (lat[d][0] == 0) begin lat[d][0] = c; dat[d][0] = a_rd[d]; err[d][0] = a_re[d]; end
          vc[d][0]++;
        end
        if (b_rv[d]) begin
          if (lat[d][1] == 0) begin lat[d][1] = c; dat[d][1] = b_rd[d]; err[d][1] = b_re[d]; end
          vc[d][1]++;
        end
      end
      if (c < 5) step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc [2];
    int wc [2];
    reset = 1'b1; reset_req = 1'b0; clear_collision = 1'b0;
    a_address = '0; b_address = '0; a_byteenable = '0; b_byteenable = '0;
    a_chipselect = 1'b0; a_read = 1'b0; a_write = 1'b0; a_clken = 1'b1; a_writedata = '0;
    b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0; b_clken = 1'b1; b_writedata = '0;
    repeat (3) step();

    // Reset state
    check_eq("rst_busy0", 32'(busy[0]), 32'd1);
    check_eq("rst_wq1", 32'(a_wq[1] & b_wq[1]), 32'd1);
    check_eq("rst_valid0", 32'(a_rv[0]), 32'd0);
    check_eq("rst_rdata1", a_rd[1], 32'h0);
    check_eq("rst_coll0", 32'(coll[0]), 32'd0);

    // Zero fill duration
    reset = 1'b0;
    bc[0] = 0; bc[1] = 0; wc[0] = 0; wc[1] = 0;
    for (int c = 0; c < 40; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) bc[d]++;
        if (a_wq[d] && b_wq[d]) wc[d]++;
      end
      step();
    end
    check_eq("fill_busy_cycles0", 32'(bc[0]), 32'd16);
    check_eq("fill_busy_cycles1", 32'(bc[1]), 32'd12);
    check_eq("fill_wq_cycles0", 32'(wc[0]), 32'd16);
    check_eq("fill_wq_cycles1", 32'(wc[1]), 32'd12);
    check_eq("ready_wq0", 32'(a_wq[0]), 32'd0);

    for (int i = 0; i < 16; i++) begin
      access(1'b1, 1'b0, 4'(i), '0, '0, 1'b0, 1'b0, '0, '0, '0);
      check_eq("fill_read0", dat[0][0], 32'h0);
      if (i < 12) check_eq("fill_read1", dat[1][0], 32'h0);
    end

    // Latency and dual-port read
    access(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, '0, '0, '0);
    check_eq("wr_no_valid", 32'(vc[0][0]), 32'd0);
    access(1'b1, 1'b0, 4'd5, '0, '0, 1'b1, 1'b0, 4'd5, '0, '0);
    check_eq("lat_a0", 32'(lat[0][0]), 32'd1);
    check_eq("lat_a1", 32'(lat[1][0]), 32'd2);
    check_eq("lat_b0", 32'(lat[0][1]), 32'd1);
    check_eq("lat_b1", 32'(lat[1][1]), 32'd2);
    check_eq("data_a0", dat[0][0], 32'hDEADBEEF);
    check_eq("data_a1", dat[1][0], 32'hDEADBEEF);
    check_eq("data_b0", dat[0][1], 32'hDEADBEEF);
    check_eq("data_b1", dat[1][1], 32'hDEADBEEF);
    check_eq("pulse_a0", 32'(vc[0][0]), 32'd1);
    check_eq("pulse_a1", 32'(vc[1][0]), 32'd1);
    check_eq("noerr_a0", 32'(err[0][0]), 32'd0);
    check_eq("hold_a0", a_rd[0], 32'hDEADBEEF);

    // Byte enables and read-during-write from the other port
    access(1'b1, 1'b1, 4'd7, 32'h11223344, 4'hF, 1'b0, 1'b0, '0, '0, '0);
    access(1'b1, 1'b1, 4'd7, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0, 4'd7, '0, '0);
    check_eq("mixed_old0", dat[0][1], 32'h11223344);
    check_eq("mixed_old1", dat[1][1], 32'h11223344);
    access(1'b1, 1'b0, 4'd7, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    check_eq("be_merge0", dat[0][0], 32'h11BB33DD);
    check_eq("be_merge1", dat[1][0], 32'h11BB33DD);

    // Collision
    check_eq("coll_before", 32'(coll[0]), 32'd0);
    access(1'b1, 1'b1, 4'd3, 32'h1, 4'hF, 1'b1, 1'b1, 4'd3, 32'h2, 4'hF);
    check_eq("coll_set0", 32'(col_after[0]), 32'd1);
    check_eq("coll_set1", 32'(col_after[1]), 32'd1);
    access(1'b1, 1'b0, 4'd3, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    check_eq("coll_data0", dat[0][0], 32'h1);
    check_eq("coll_data1", dat[1][0], 32'h1);
    check_eq("coll_sticky", 32'(coll[0]), 32'd1);
    clear_collision = 1'b1;
    step();
    clear_collision = 1'b0;
    check_eq("coll_clear0", 32'(coll[0]), 32'd0);
    check_eq("coll_clear1", 32'(coll[1]), 32'd0);
    clear_collision = 1'b1;
    access(1'b1, 1'b1, 4'd3, 32'h5, 4'hF, 1'b1, 1'b1, 4'd3, 32'h6, 4'hF);
    clear_collision = 1'b0;
    check_eq("coll_set_wins", 32'(col_after[0]), 32'd1);
    clear_collision = 1'b1;
    step();
    clear_collision = 1'b0;
    check_eq("coll_clear_again", 32'(coll[0]), 32'd0);

    // clken stall on port A
    a_chipselect = 1'b1; a_read = 1'b1; a_address = 4'd5;
    step();
    a_chipselect = 1'b0; a_read = 1'b0; a_clken = 1'b0;
    for (int d = 0; d < 2; d++) begin lat[d][0] = 0; vc[d][0] = 0; dat[d][0] = 32'hx; end
    for (int c = 1; c <= 8; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (a_rv[d]) begin
          if (lat[d][0] == 0) begin lat[d][0] = c; dat[d][0] = a_rd[d]; end
          vc[d][0]++;
        end
      end
      if (c == 4) a_clken = 1'b1;
      step();
    end
    check_eq("stall_lat1", 32'(lat[1][0]), 32'd5);
    check_eq("stall_data1", dat[1][0], 32'hDEADBEEF);
    check_eq("stall_pulse1", 32'(vc[1][0]), 32'd1);
    check_eq("stall_lat0", 32'(lat[0][0]), 32'd1);
    check_eq("stall_hold0", 32'(vc[0][0]), 32'd4);

    // reset_req freeze
    reset_req = 1'b1;
    #1;
    check_eq("rreq_wq_a0", 32'(a_wq[0]), 32'd1);
    check_eq("rreq_wq_b1", 32'(b_wq[1]), 32'd1);
    access(1'b1, 1'b0, 4'd5, '0, '0, 1'b1, 1'b0, 4'd5, '0, '0);
    check_eq("rreq_noacc0", 32'(vc[0][0] + vc[0][1]), 32'd0);
    check_eq("rreq_noacc1", 32'(vc[1][0] + vc[1][1]), 32'd0);
    reset_req = 1'b0;
    #1;
    check_eq("rreq_release", 32'(a_wq[0]), 32'd0);

    // Out-of-range access on the DEPTH=12 instance
    access(1'b1, 1'b1, 4'd13, 32'h13131313, 4'hF, 1'b0, 1'b0, '0, '0, '0);
    access(1'b1, 1'b0, 4'd13, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    check_eq("oor_in_range0", dat[0][0], 32'h13131313);
    check_eq("oor_data1", dat[1][0], 32'h0);
    check_eq("oor_lat1", 32'(lat[1][0]), 32'd2);
    check_eq("oor_noerr1", 32'(err[1][0]), 32'd0);

`ifdef MCS_DPRAM_PARITY_EN
    // Parity error detection after a backdoor bit flip
    access(1'b1, 1'b1, 4'd2, 32'h0000A55A, 4'hF, 1'b0, 1'b0, '0, '0, '0);
    u_dut0.mem[2] <= u_dut0.mem[2] ^ 32'h00000200;
    step();
    access(1'b1, 1'b0, 4'd2, '0, '0, 1'b1, 1'b0, 4'd5, '0, '0);
    check_eq("par_err_a0", 32'(err[0][0]), 32'd1);
    check_eq("par_err_lat", 32'(lat[0][0]), 32'd1);
    check_eq("par_clean_b0", 32'(err[0][1]), 32'd0);
    check_eq("par_clean_a1", 32'(err[1][0]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
